tamagotchi_need_bank: RTL and testbench

Parametrised need-level engine for the Tamagotchi pet: holds `NUM_NEEDS` independent saturating levels (health, energy, hunger, fun, ...), raises them from per-need care buttons, and lowers them from per-need decay timers driven by a shared tick divider. It also drives the pet's mood, alarm and 7-segment outputs for the currently selected need. It replaces the fixed four-need FSM and adds:
- runtime decay periods,
- per-need recovery mode (e.g. energy while sleeping),
- synchronised edge-detected buttons,
- a toggling test mode.

---
 rtl/tamagotchi_need_bank.sv | 217 +++++++++++++++++++++
 tb/tb_tamagotchi_need_bank.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tamagotchi_need_bank.sv
// tamagotchi_need_bank: NUM_NEEDS saturating need levels raised by care buttons
// and moved by per-need decay timers paced by a shared tick divider. Also
// drives mood, alarm and a 7-segment digit for the selected need.
module tamagotchi_need_bank #(
    parameter int NUM_NEEDS    = 4,
    parameter int LEVEL_W      = 4,
    parameter int LEVEL_MAX    = 10,
    parameter int LEVEL_INIT   = 8,
    parameter int HAPPY_THRESH = 5,
    parameter int TICK_DIV     = 1000000,
    parameter int SEL_W        = 2
) (
    input  logic                         clk,
    input  logic                         btn_reset,
    input  logic [NUM_NEEDS-1:0]         btn_need,
    input  logic                         btn_test,
    input  logic [NUM_NEEDS-1:0]         recover,
    input  logic [8*NUM_NEEDS-1:0]       decay_period,
    output logic [LEVEL_W*NUM_NEEDS-1:0] level_bus,
    output logic [SEL_W-1:0]             sel,
    output logic                         happy,
    output logic [6:0]                   seg,
    output logic                         alarm,
    output logic                         test_mode,
    output logic                         tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    // Active-low 7-segment pattern, g..a from MSB to LSB; 10 shows "A".
    function automatic logic [6:0] seg_code(input logic [LEVEL_W-1:0] v);
        logic [6:0] s;
        case (int'(v))
            0:       s = 7'b1000000;
            1:       s = 7'b1111001;
            2:       s = 7'b0100100;
            3:       s = 7'b0110000;
            4:       s = 7'b0011001;
            5:       s = 7'b0010010;
            6:       s = 7'b0000010;
            7:       s = 7'b1111000;
            8:       s = 7'b0000000;
            9:       s = 7'b0010000;
            10:      s = 7'b0001000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [NUM_NEEDS-1:0] need_s1_q, need_s1_d, need_s2_q, need_s2_d, need_dly_q, need_dly_d;
    logic                 test_s1_q, test_s1_d, test_s2_q, test_s2_d, test_dly_q, test_dly_d;
    logic [NUM_NEEDS-1:0] press_need;
    logic                 press_test;
    logic                 win_valid;
    logic [SEL_W-1:0]     win_idx;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic                 test_mode_q, test_mode_d;
    logic                 happy_q, happy_d;
    logic [6:0]           seg_q, seg_d;
    logic                 alarm_q, alarm_d;
    logic [LEVEL_W-1:0]   sel_level;
    logic [NUM_NEEDS-1:0] zero_vec;

    // Next values of the two-flop synchronisers and the edge-detect history
    always_comb begin
        need_s1_d  = btn_need;
        need_s2_d  = need_s1_q;
        need_dly_d = need_s2_q;
        test_s1_d  = btn_test;
        test_s2_d  = test_s1_q;
        test_dly_d = test_s2_q;
    end

    // Synchroniser and edge-detect registers
    always_ff @(posedge clk or posedge btn_reset) begin
        if (btn_reset) begin
            need_s1_q  <= '0;
            need_s2_q  <= '0;
            need_dly_q <= '0;
            test_s1_q  <= 1'b0;
            test_s2_q  <= 1'b0;
            test_dly_q <= 1'b0;
        end else begin
            need_s1_q  <= need_s1_d;
            need_s2_q  <= need_s2_d;
            need_dly_q <= need_dly_d;
            test_s1_q  <= test_s1_d;
            test_s2_q  <= test_s2_d;
            test_dly_q <= test_dly_d;
        end
    end

    assign press_need = need_s2_q & ~need_dly_q;
    assign press_test = test_s2_q & ~test_dly_q;

    // Lowest-index press wins; scanning downward leaves the lowest one last
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = NUM_NEEDS - 1; i >= 0; i--) begin
            if (press_need[i]) begin
                win_valid = 1'b1;
                win_idx   = SEL_W'(i);
            end
        end
    end

    // Free-running tick divider, wrapping on the tick cycle
    assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_NEEDS; gi++) begin : g_need
            logic [7:0]         period;
            logic [7:0]         timer_q, timer_d;
            logic               ev;
            logic               hit;
            logic [LEVEL_W-1:0] level_q, level_d;
            int                 sum;

            assign period = decay_period[gi*8 +: 8];

            // Decay timer: a disabled period pins it to 0; test mode freezes it.
            // Using >= lets a shortened period fire on the next tick.
            always_comb begin
                timer_d = timer_q;
                ev      = 1'b0;
                if (period == 8'd0) begin
                    timer_d = 8'd0;
                end else if (!test_mode_q && tick) begin
                    if (timer_q >= period - 8'd1) begin
                        ev      = 1'b1;
                        timer_d = 8'd0;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
            end

            // Level update: press and event add as a net delta, then clamp
            always_comb begin
                hit = win_valid && (win_idx == SEL_W'(gi)) && (win_idx == sel_q);
                sum = int'(level_q);
                if (hit && test_mode_q) begin
                    sum = (level_q == LEVEL_W'(1)) ? LEVEL_MAX : 1;
                end else begin
                    if (hit) sum = sum + 1;
                    if (ev)  sum = recover[gi] ? sum + 1 : sum - 1;
                end
                if (sum < 0) sum = 0;
                else if (sum > LEVEL_MAX) sum = LEVEL_MAX;
                level_d = LEVEL_W'(sum);
            end

            // Per-need timer and level registers
            always_ff @(posedge clk or posedge btn_reset) begin
                if (btn_reset) begin
                    timer_q <= 8'd0;
                    level_q <= LEVEL_W'(LEVEL_INIT);
                end else begin
                    timer_q <= timer_d;
                    level_q <= level_d;
                end
            end

            assign level_bus[gi*LEVEL_W +: LEVEL_W] = level_q;
            assign zero_vec[gi] = (level_q == '0);
        end
    endgenerate

    // Selection moves on a press of another need; test button toggles mode
    always_comb begin
        sel_d       = (win_valid && (win_idx != sel_q)) ? win_idx : sel_q;
        test_mode_d = test_mode_q ^ press_test;
    end

    // Display outputs derived from the already-updated state, one edge later
    always_comb begin
        sel_level = '0;
        for (int i = 0; i < NUM_NEEDS; i++) begin
            if (sel_q == SEL_W'(i)) sel_level = level_bus[i*LEVEL_W +: LEVEL_W];
        end
        happy_d = (int'(sel_level) >= HAPPY_THRESH);
        seg_d   = seg_code(sel_level);
        alarm_d = |zero_vec;
    end

    // Divider, selection, mode and display registers
    always_ff @(posedge clk or posedge btn_reset) begin
        if (btn_reset) begin
            cnt_q       <= '0;
            sel_q       <= '0;
            test_mode_q <= 1'b0;
            happy_q     <= (LEVEL_INIT >= HAPPY_THRESH);
            seg_q       <= seg_code(LEVEL_W'(LEVEL_INIT));
            alarm_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            test_mode_q <= test_mode_d;
            happy_q     <= happy_d;
            seg_q       <= seg_d;
            alarm_q     <= alarm_d;
        end
    end

    assign sel       = sel_q;
    assign test_mode = test_mode_q;
    assign happy     = happy_q;
    assign seg       = seg_q;
    assign alarm     = alarm_q;

endmodule

// File: tb/tb_tamagotchi_need_bank.sv
// Scoreboard bench for tamagotchi_need_bank: a behavioural model pushes the
// expected visible state after every clock edge; a monitor compares it.
module tb_tamagotchi_need_bank;

    localparam int NN = 4;
    localparam int LW = 4;
    localparam int LMAX = 10;
    localparam int LINIT = 8;
    localparam int HT = 5;
    localparam int TD = 4;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              btn_reset = 1'b0;
    logic [NN-1:0]     btn_need = '0;
    logic              btn_test = 1'b0;
    logic [NN-1:0]     recover = '0;
    logic [8*NN-1:0]   decay_period = '0;
    logic [LW*NN-1:0]  level_bus;
    logic [SW-1:0]     sel;
    logic              happy;
    logic [6:0]        seg;
    logic              alarm;
    logic              test_mode;
    logic              tick;

    tamagotchi_need_bank #(
        .NUM_NEEDS(NN), .LEVEL_W(LW), .LEVEL_MAX(LMAX), .LEVEL_INIT(LINIT),
        .HAPPY_THRESH(HT), .TICK_DIV(TD), .SEL_W(SW)
    ) dut (
        .clk(clk), .btn_reset(btn_reset), .btn_need(btn_need), .btn_test(btn_test),
        .recover(recover), .decay_period(decay_period), .level_bus(level_bus),
        .sel(sel), .happy(happy), .seg(seg), .alarm(alarm),
        .test_mode(test_mode), .tick(tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lv[NN];
        int sel;
        int tm;
        int happy;
        int seg;
        int alarm;
        int tick;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;

    function automatic int seg_of(int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            10: return 7'b0001000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] t=%0t FAIL %s: got %0d expected %0d", $time, name, act, expv);
        end
    endtask

    // ---------------- behavioural model ----------------
    int       m_level[NN];
    int       m_ticks[NN];   // ticks accumulated toward the next decay event
    int       m_sel, m_tm, m_cycles, m_happy, m_seg, m_alarm;
    bit [2:0] hist_need[NN]; // raw samples at edges n-1, n-2, n-3 (bit0 newest)
    bit [2:0] hist_test;

    function automatic exp_t reset_snap();
        exp_t e;
        for (int i = 0; i < NN; i++) e.lv[i] = LINIT;
        e.sel = 0; e.tm = 0; e.happy = (LINIT >= HT) ? 1 : 0;
        e.seg = seg_of(LINIT); e.alarm = 0; e.tick = 0;
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NN; i++) begin
            m_level[i] = LINIT; m_ticks[i] = 0; hist_need[i] = 3'b000;
        end
        hist_test = 3'b000;
        m_sel = 0; m_tm = 0; m_cycles = 0;
        m_happy = (LINIT >= HT) ? 1 : 0; m_seg = seg_of(LINIT); m_alarm = 0;
    endtask

    task automatic model_step();
        bit   pressed[NN];
        bit   tpress;
        bit   is_tick;
        int   winner;
        int   per;
        int   v;
        exp_t e;
        // a press takes effect two edges after the raw level is first seen
        for (int i = 0; i < NN; i++) begin
            pressed[i] = hist_need[i][1] && !hist_need[i][2];
            hist_need[i] = {hist_need[i][1:0], btn_need[i]};
        end
        tpress = hist_test[1] && !hist_test[2];
        hist_test = {hist_test[1:0], btn_test};
        is_tick = (m_cycles % TD) == TD - 1;
        m_cycles++;
        // display outputs reflect the state before this edge
        m_happy = (m_level[m_sel] >= HT) ? 1 : 0;
        m_seg = seg_of(m_level[m_sel]);
        m_alarm = 0;
        for (int i = 0; i < NN; i++) if (m_level[i] == 0) m_alarm = 1;
        winner = -1;
        for (int i = NN - 1; i >= 0; i--) if (pressed[i]) winner = i;
        for (int i = 0; i < NN; i++) begin
            per = int'(decay_period[i*8 +: 8]);
            v = m_level[i];
            if (winner == i && winner == m_sel && m_tm == 1) begin
                v = (v == 1) ? LMAX : 1;
            end else if (winner == i && winner == m_sel) begin
                v = v + 1;
            end
            if (per == 0) begin
                m_ticks[i] = 0;
            end else if (m_tm == 0 && is_tick) begin
                m_ticks[i] = m_ticks[i] + 1;
                if (m_ticks[i] >= per) begin
                    m_ticks[i] = 0;
                    v = recover[i] ? v + 1 : v - 1;
                end
            end
            if (v < 0) v = 0;
            if (v > LMAX) v = LMAX;
            m_level[i] = v;
        end
        if (winner >= 0 && winner != m_sel) m_sel = winner;
        if (tpress) m_tm = 1 - m_tm;
        for (int i = 0; i < NN; i++) e.lv[i] = m_level[i];
        e.sel = m_sel; e.tm = m_tm; e.happy = m_happy; e.seg = m_seg;
        e.alarm = m_alarm; e.tick = ((m_cycles % TD) == TD - 1) ? 1 : 0;
        exp_q.push_back(e);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge btn_reset);
            if (btn_reset) begin
                model_reset();
                exp_q.delete();
            end else begin
                model_step();
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 1) begin
                chk("queue_depth", exp_q.size(), 1);
                while (exp_q.size() > 1) void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = reset_snap();
            for (int i = 0; i < NN; i++)
                chk($sformatf("level%0d", i), int'(level_bus[i*LW +: LW]), e.lv[i]);
            chk("sel", int'(sel), e.sel);
            chk("test_mode", int'(test_mode), e.tm);
            chk("happy", int'(happy), e.happy);
            chk("seg", int'(seg), e.seg);
            chk("alarm", int'(alarm), e.alarm);
            chk("tick", int'(tick), e.tick);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int i);
        btn_need[i] = 1'b1;
        cyc(3);
        btn_need[i] = 1'b0;
        cyc(3);
    endtask

    task automatic press_test_btn();
        btn_test = 1'b1;
        cyc(3);
        btn_test = 1'b0;
        cyc(3);
    endtask

    // Reset asserted between edges must act at once
    task automatic async_reset();
        @(posedge clk);
        #2;
        btn_reset = 1'b1;
        #1;
        chk("async_rst_levels", int'(level_bus), 32'h8888);
        chk("async_rst_sel", int'(sel), 0);
        chk("async_rst_tm", int'(test_mode), 0);
        cyc(2);
        btn_reset = 1'b0;
        cyc(2);
    endtask

    initial begin
        #1 btn_reset = 1'b1;
        cyc(3);
        btn_reset = 1'b0;
        cyc(2);

        // selection, then saturation on need 1
        press(2);
        press(1);
        press(1);
        press(1);
        press(1);

        // decay and alarm
        decay_period = {8'd3, 8'd0, 8'd0, 8'd1};
        cyc(40);
        async_reset();

        // recovery with presses landing at varied offsets from the tick
        decay_period = {8'd0, 8'd0, 8'd1, 8'd0};
        recover = 4'b0010;
        press(1);
        for (int k = 0; k < 8; k++) begin
            btn_need[1] = 1'b1;
            cyc(2 + (k % 4));
            btn_need[1] = 1'b0;
            cyc(1 + (k % 3));
        end
        decay_period = 0;
        recover = 0;
        async_reset();

        // test mode: set-to-1 / set-to-max, frozen timers, then resume
        decay_period = {8'd2, 8'd1, 8'd3, 8'd1};
        press_test_btn();
        press(0);
        press(0);
        cyc(400);
        press_test_btn();
        cyc(40);

        // randomized operation
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(3) == 0) btn_need[$urandom_range(NN - 1)] ^= 1'b1;
            if ($urandom_range(31) == 0) btn_test = ~btn_test;
            if ($urandom_range(99) == 0) begin
                for (int i = 0; i < NN; i++) decay_period[i*8 +: 8] = 8'($urandom_range(5));
                recover = 4'($urandom_range(15));
            end
            cyc(1);
        end
        btn_need = '0;
        btn_test = 1'b0;
        cyc(6);

        // simultaneous presses: lowest index wins, then async reset
        decay_period = 0;
        btn_need = 4'b1010;
        cyc(4);
        btn_need = '0;
        cyc(3);
        async_reset();
        cyc(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
